ascii_to_bcd_3: RTL and testbench
=================================

Name: ascii_to_bcd_3

Overview:
Receives a stream of ASCII characters, one per handshake, from the keypad/UART front end of the soda machine. It assembles up to three decimal digits into a 10-bit BCD value: hundreds in 2 bits, tens in 4 bits, ones in 4 bits. The assembled value goes to the price/credit logic. It is the inverse of the BCD-to-text display path. It uses a valid/ready handshake on both sides, supports backspace editing, and flags malformed input.

Parameters:
TERM_CHAR, 8'h0D, ASCII terminator that commits the entry (CR); 8'h0A (LF) is also always accepted as a terminator
BS_CHAR, 8'h08, ASCII backspace; removes the most recent digit

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
char_in  input  8  ASCII character
char_valid  input  1  char_in is valid
char_ready  output  1  block accepts char_in this cycle
bcd_out  output  10  {hundreds[1:0], tens[3:0], ones[3:0]}
bcd_valid  output  1  bcd_out holds a committed value
bcd_ready  input  1  downstream consumes bcd_out
error  output  1  one-cycle pulse on a malformed entry
digit_count  output  2  number of digits currently held (0-3), for echo/display

Behaviour:
- Reset: async on rst_n low. State=COLLECT, digit registers cleared, digit_count=0, bcd_out=0, bcd_valid=0, error=0. char_ready=1 once rst_n is deasserted.
- Char transfer happens on a clk edge with char_valid && char_ready. Result transfer happens on an edge with bcd_valid && bcd_ready.
- Internal digit registers h, t, o are each 4 bits. digit_count is a 2-bit counter.
- State COLLECT (char_ready=1). For each accepted char:
  - Digit 0x30-0x39 with digit_count<3: shift in (h<=t, t<=o, o<=char-0x30), digit_count++.
  - Digit with digit_count==3: error pulse next cycle; go to DISCARD.
  - BS_CHAR with digit_count>0: shift out (o<=t, t<=h, h<=0), digit_count--. With digit_count==0: no effect, no error.
  - Space 0x20: ignored.
  - Terminator with digit_count==0: ignored, no error.
  - Terminator with digit_count>0 and h<=3: bcd_out<={h[1:0],t,o}, bcd_valid=1 from the next cycle; clear digit registers and count; go to EMIT.
  - Terminator with h>3 (value >399): error pulse; clear registers; stay in COLLECT; no output.
  - Any other char: error pulse; go to DISCARD.
- State DISCARD (char_ready=1): drop every char until a terminator. On the terminator, clear registers and count and return to COLLECT. No further error pulses while in DISCARD.
- State EMIT (char_ready=0):
  - bcd_valid=1 and bcd_out held stable until the transfer.
  - On bcd_ready: bcd_valid=0 next cycle; return to COLLECT. A char is accepted no earlier than the cycle after the transfer.
  - bcd_out keeps its last value after the transfer; only bcd_valid qualifies it.
- Leading zeros are permitted: "007" yields 0x007. Fewer than three digits are right-justified: "42" yields {2'b00,4'd4,4'd2}.
- Latency: bcd_valid rises exactly one cycle after the terminator transfer. error rises one cycle after the offending char transfer and lasts exactly one cycle.
- char_in is ignored whenever char_valid=0. A char is never lost while char_ready=1.
- rst_n asserted mid-entry or during EMIT: all state is cleared immediately, with no output or error.

Test Plan:
- "1","2","5",CR with bcd_ready=1 -> bcd_valid one cycle after CR, bcd_out=10'b01_0010_0101, digit_count 1,2,3 then 0; char_ready low during EMIT.
- "4","2",LF, bcd_ready held 0 for 5 cycles then 1 -> bcd_out={00,4,2} stable and char_ready=0 for all 5 cycles; bcd_valid falls the cycle after bcd_ready.
- "9",BS,"3",BS,BS,"7",CR -> bcd_out=0x007; no error pulse.
- "4","5","6",CR -> single error pulse, bcd_valid never rises, digit_count=0 afterwards.
- "1","2","3","4","5",CR, then "8",CR -> one error after the 4th digit; "5" and CR dropped; then bcd_out=0x008.
- "1","A","2",CR, "3",CR with rst_n pulsed low in the middle of a second "6","7" entry -> error after "A", no output for the first entry, bcd_out=0x003; after reset bcd_valid=0, digit_count=0, no output for "67".

Source files
------------

// File: rtl/ascii_to_bcd_3.sv
// ascii_to_bcd_3: turns a keypad/UART character stream into a 3-digit BCD
// value (hundreds 0-3, tens, ones). Supports backspace editing, accepts CR or
// LF as the commit character, and flags malformed entries with a one-cycle
// error pulse.
module ascii_to_bcd_3 #(
  parameter logic [7:0] TERM_CHAR = 8'h0D,
  parameter logic [7:0] BS_CHAR   = 8'h08
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] char_in,
  input  logic       char_valid,
  output logic       char_ready,
  output logic [9:0] bcd_out,
  output logic       bcd_valid,
  input  logic       bcd_ready,
  output logic       error,
  output logic [1:0] digit_count
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DISCARD = 2'd1,
    EMIT    = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] h_q, h_d;
  logic [3:0] t_q, t_d;
  logic [3:0] o_q, o_d;
  logic [1:0] cnt_q, cnt_d;
  logic [9:0] bcd_q, bcd_d;
  logic       err_q, err_d;

  logic       is_digit;
  logic       is_term;
  logic       is_bs;
  logic       is_space;

  // Character classification of the current input byte.
  always_comb begin
    is_digit = (char_in >= 8'h30) && (char_in <= 8'h39);
    is_term  = (char_in == TERM_CHAR) || (char_in == 8'h0A);
    is_bs    = (char_in == BS_CHAR);
    is_space = (char_in == 8'h20);
  end

  // Next-state and datapath decode; the block only stalls input while a
  // committed value waits to be taken downstream.
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    t_d     = t_q;
    o_d     = o_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    err_d   = 1'b0;

    case (state_q)
      COLLECT: begin
        if (char_valid) begin
          if (is_digit) begin
            if (cnt_q == 2'd3) begin
              // Fourth digit: the whole entry is bad, skip to the terminator.
              err_d   = 1'b1;
              state_d = DISCARD;
            end else begin
              h_d   = t_q;
              t_d   = o_q;
              o_d   = char_in[3:0];
              cnt_d = cnt_q + 2'd1;
            end
          end else if (is_bs) begin
            if (cnt_q != 2'd0) begin
              o_d   = t_q;
              t_d   = h_q;
              h_d   = 4'd0;
              cnt_d = cnt_q - 2'd1;
            end
          end else if (is_space) begin
            // Spaces are cosmetic; nothing changes.
          end else if (is_term) begin
            if (cnt_q != 2'd0) begin
              if (h_q <= 4'd3) begin
                bcd_d   = {h_q[1:0], t_q, o_q};
                state_d = EMIT;
              end else begin
                // Value above 399 cannot be represented in two hundreds bits.
                err_d = 1'b1;
              end
              h_d   = 4'd0;
              t_d   = 4'd0;
              o_d   = 4'd0;
              cnt_d = 2'd0;
            end
          end else begin
            err_d   = 1'b1;
            state_d = DISCARD;
          end
        end
      end

      DISCARD: begin
        if (char_valid && is_term) begin
          h_d     = 4'd0;
          t_d     = 4'd0;
          o_d     = 4'd0;
          cnt_d   = 2'd0;
          state_d = COLLECT;
        end
      end

      EMIT: begin
        if (bcd_ready) begin
          state_d = COLLECT;
        end
      end

      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  // State and datapath registers, cleared immediately by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      h_q     <= 4'd0;
      t_q     <= 4'd0;
      o_q     <= 4'd0;
      cnt_q   <= 2'd0;
      bcd_q   <= 10'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      t_q     <= t_d;
      o_q     <= o_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      err_q   <= err_d;
    end
  end

  assign char_ready  = (state_q != EMIT);
  assign bcd_valid   = (state_q == EMIT);
  assign bcd_out     = bcd_q;
  assign error       = err_q;
  assign digit_count = cnt_q;

endmodule

// File: tb/tb_ascii_to_bcd_3.sv
// Directed testbench for ascii_to_bcd_3: hand-computed expectations checked
// with immediate assertions after each step.
module tb_ascii_to_bcd_3;

  logic       clk;
  logic       rst_n;
  logic [7:0] char_in;
  logic       char_valid;
  logic       char_ready;
  logic [9:0] bcd_out;
  logic       bcd_valid;
  logic       bcd_ready;
  logic       error;
  logic [1:0] digit_count;

  int n_cmp;
  int n_bad;
  int err_pulses;

  ascii_to_bcd_3 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .char_in     (char_in),
    .char_valid  (char_valid),
    .char_ready  (char_ready),
    .bcd_out     (bcd_out),
    .bcd_valid   (bcd_valid),
    .bcd_ready   (bcd_ready),
    .error       (error),
    .digit_count (digit_count)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count error-high cycles, sampled away from the active edge.
  always @(negedge clk) begin
    if (error === 1'b1) err_pulses++;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One char transfer; outputs are valid on return (#1 after the edge).
  task automatic send(input logic [7:0] c);
    @(negedge clk);
    char_in    = c;
    char_valid = 1'b1;
    chk("char_ready_before_send", {31'd0, char_ready}, 32'd1);
    @(posedge clk);
    #1;
    char_valid = 1'b0;
    char_in    = 8'h00;
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    err_pulses = 0;
    rst_n      = 1'b0;
    char_in    = 8'h00;
    char_valid = 1'b0;
    bcd_ready  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bcd_valid", {31'd0, bcd_valid}, 32'd0);
    chk("rst_bcd_out", {22'd0, bcd_out}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_digit_count", {30'd0, digit_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_char_ready", {31'd0, char_ready}, 32'd1);

    // "125" CR, downstream always ready
    bcd_ready = 1'b1;
    send(8'h31); chk("t1_cnt1", {30'd0, digit_count}, 32'd1);
    send(8'h32); chk("t1_cnt2", {30'd0, digit_count}, 32'd2);
    send(8'h35); chk("t1_cnt3", {30'd0, digit_count}, 32'd3);
    send(8'h0D);
    chk("t1_valid", {31'd0, bcd_valid}, 32'd1);
    chk("t1_bcd", {22'd0, bcd_out}, 32'h125);
    chk("t1_cnt0", {30'd0, digit_count}, 32'd0);
    chk("t1_ready_low", {31'd0, char_ready}, 32'd0);
    @(posedge clk); #1;
    chk("t1_valid_fall", {31'd0, bcd_valid}, 32'd0);
    chk("t1_ready_back", {31'd0, char_ready}, 32'd1);

    // "42" LF with downstream stalled for 5 cycles
    bcd_ready = 1'b0;
    send(8'h34);
    send(8'h32);
    send(8'h0A);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      chk("t2_hold_valid", {31'd0, bcd_valid}, 32'd1);
      chk("t2_hold_bcd", {22'd0, bcd_out}, 32'h042);
      chk("t2_hold_ready", {31'd0, char_ready}, 32'd0);
    end
    @(negedge clk);
    bcd_ready = 1'b1;
    @(posedge clk); #1;
    chk("t2_valid_fall", {31'd0, bcd_valid}, 32'd0);
    chk("t2_bcd_kept", {22'd0, bcd_out}, 32'h042);

    // "9" BS "3" BS BS "7" CR -> 007
    send(8'h39); chk("t3_cnt_9", {30'd0, digit_count}, 32'd1);
    send(8'h08); chk("t3_cnt_bs1", {30'd0, digit_count}, 32'd0);
    send(8'h33);
    send(8'h08);
    send(8'h08); chk("t3_cnt_bs_empty", {30'd0, digit_count}, 32'd0);
    chk("t3_no_err_bs_empty", {31'd0, error}, 32'd0);
    send(8'h37);
    send(8'h0D);
    chk("t3_valid", {31'd0, bcd_valid}, 32'd1);
    chk("t3_bcd", {22'd0, bcd_out}, 32'h007);
    @(posedge clk); #1;
    chk("t3_err_total", err_pulses, 32'd0);

    // "456" CR -> over range
    send(8'h34);
    send(8'h35);
    send(8'h36);
    send(8'h0D);
    chk("t4_error", {31'd0, error}, 32'd1);
    chk("t4_valid", {31'd0, bcd_valid}, 32'd0);
    chk("t4_cnt", {30'd0, digit_count}, 32'd0);
    @(posedge clk); #1;
    chk("t4_error_one_cycle", {31'd0, error}, 32'd0);
    chk("t4_valid_later", {31'd0, bcd_valid}, 32'd0);

    // "12345" CR then "8" CR
    send(8'h31);
    send(8'h32);
    send(8'h33);
    send(8'h34);
    chk("t5_error_4th", {31'd0, error}, 32'd1);
    send(8'h35);
    chk("t5_no_err_discard", {31'd0, error}, 32'd0);
    send(8'h0D);
    chk("t5_valid_discard", {31'd0, bcd_valid}, 32'd0);
    chk("t5_cnt", {30'd0, digit_count}, 32'd0);
    send(8'h38);
    send(8'h0D);
    chk("t5_valid", {31'd0, bcd_valid}, 32'd1);
    chk("t5_bcd", {22'd0, bcd_out}, 32'h008);
    @(posedge clk); #1;

    // "1A2" CR, "3" CR, then reset in the middle of "67"
    send(8'h31);
    send(8'h41);
    chk("t6_error_A", {31'd0, error}, 32'd1);
    send(8'h32);
    send(8'h0D);
    chk("t6_valid_bad", {31'd0, bcd_valid}, 32'd0);
    send(8'h33);
    send(8'h0D);
    chk("t6_valid", {31'd0, bcd_valid}, 32'd1);
    chk("t6_bcd", {22'd0, bcd_out}, 32'h003);
    @(posedge clk); #1;
    send(8'h36);
    chk("t6_cnt_6", {30'd0, digit_count}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_cnt", {30'd0, digit_count}, 32'd0);
    chk("t6_rst_valid", {31'd0, bcd_valid}, 32'd0);
    chk("t6_rst_error", {31'd0, error}, 32'd0);
    chk("t6_rst_bcd", {22'd0, bcd_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h37);
    chk("t6_cnt_7", {30'd0, digit_count}, 32'd1);
    chk("t6_valid_7", {31'd0, bcd_valid}, 32'd0);
    send(8'h08);
    chk("t6_cnt_cleared", {30'd0, digit_count}, 32'd0);

    // Reset while a value is waiting in EMIT
    bcd_ready = 1'b0;
    send(8'h35);
    send(8'h0D);
    chk("t7_valid", {31'd0, bcd_valid}, 32'd1);
    chk("t7_bcd", {22'd0, bcd_out}, 32'h005);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_rst_valid", {31'd0, bcd_valid}, 32'd0);
    chk("t7_rst_ready", {31'd0, char_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Exactly three error pulses over the whole run
    chk("err_pulse_total", err_pulses, 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
